if_fetch_unit: RTL

//  IF stage ahead of ID: owns the PC, chooses the next PC and fetches over an SRAM-like bus.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/if_npc_mux.sv | 50 +++++
 rtl/if_fetch_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: fetch FSM encoding, reset vector and the nop encoding.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

  localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_npc_mux.sv
// Next-PC select for the fetch unit: flush > pending redirect > live ID redirect > pc+4.
// The live ID redirect (jr > j/jal > branch) is also exported so the top can latch it.
module if_npc_mux #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              pend_v_i,
  input  logic [ADDR_W-1:0] pend_pc_i,
  input  logic              do_branch_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              jump_flag_i,
  input  logic [25:0]       jump_index_i,
  input  logic [ADDR_W-1:0] id_pc4_i,
  input  logic              jr_flag_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  input  logic              id_branch_stall_i,
  output logic              id_redir_v_o,
  output logic [ADDR_W-1:0] id_redir_pc_o,
  output logic [ADDR_W-1:0] next_pc_o
);

  logic [ADDR_W-1:0] jump_target;
  logic              unused_pc4_low;

  // j/jal keep the 256 MB region of the delay-slot PC
  assign jump_target    = {id_pc4_i[ADDR_W-1:28], jump_index_i, 2'b00};
  assign unused_pc4_low = ^id_pc4_i[27:0];

  always_comb begin
    id_redir_v_o  = !id_branch_stall_i && (jr_flag_i || jump_flag_i || do_branch_i);
    id_redir_pc_o = branch_addr_i;
    if (jr_flag_i) begin
      id_redir_pc_o = jr_target_i;
    end else if (jump_flag_i) begin
      id_redir_pc_o = jump_target;
    end

    next_pc_o = pc_i + ADDR_W'(4);
    if (flush_i) begin
      next_pc_o = flush_pc_i;
    end else if (pend_v_i) begin
      next_pc_o = pend_pc_i;
    end else if (id_redir_v_o) begin
      next_pc_o = id_redir_pc_o;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, fetches over an SRAM-like bus and holds one instruction for ID.
// Optional IF_ADEL_EN: misaligned PCs raise if_adel_o instead of issuing a bus request.
module if_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hBFC0_0000)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              do_branch_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              jump_flag_i,
  input  logic [25:0]       jump_index_i,
  input  logic [ADDR_W-1:0] id_pc4_i,
  input  logic              jr_flag_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  input  logic              id_branch_stall_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_addr_ok_i,
  input  logic              inst_data_ok_i,
  input  logic [31:0]       inst_rdata_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [ADDR_W-1:0] if_pc4_o,
  output logic [31:0]       if_instr_o,
  output logic              if_valid_o,
  output logic              if_adel_o,
  output logic              if_stall_req_o
);

  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              buf_v_q, buf_v_d;
  logic [31:0]       buf_q, buf_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              kill_q, kill_d;
  logic              adel_q, adel_d;

  logic              id_redir_v;
  logic [ADDR_W-1:0] id_redir_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] eff_addr;
  logic              misaligned;

  if_npc_mux #(
    .ADDR_W(ADDR_W)
  ) u_npc_mux (
    .pc_i             (pc_q),
    .flush_i          (flush_i),
    .flush_pc_i       (flush_pc_i),
    .pend_v_i         (pend_v_q),
    .pend_pc_i        (pend_pc_q),
    .do_branch_i      (do_branch_i),
    .branch_addr_i    (branch_addr_i),
    .jump_flag_i      (jump_flag_i),
    .jump_index_i     (jump_index_i),
    .id_pc4_i         (id_pc4_i),
    .jr_flag_i        (jr_flag_i),
    .jr_target_i      (jr_target_i),
    .id_branch_stall_i(id_branch_stall_i),
    .id_redir_v_o     (id_redir_v),
    .id_redir_pc_o    (id_redir_pc),
    .next_pc_o        (next_pc)
  );

  // A flush in REQ retargets the request in the same cycle
  assign eff_addr = flush_i ? flush_pc_i : pc_q;

`ifdef IF_ADEL_EN
  assign misaligned = |eff_addr[1:0];
  assign if_adel_o  = adel_q;
`else
  assign misaligned = 1'b0;
  assign if_adel_o  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_v_d     = buf_v_q;
    buf_d       = buf_q;
    pend_v_d    = pend_v_q;
    pend_pc_d   = pend_pc_q;
    kill_d      = kill_q;
    adel_d      = adel_q;
    inst_req_o  = 1'b0;
    inst_addr_o = pc_q;

    // First redirect wins; the fetch in flight is the delay slot
    if (id_redir_v && !pend_v_q) begin
      pend_v_d  = 1'b1;
      pend_pc_d = id_redir_pc;
    end

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (flush_i) begin
          pc_d = flush_pc_i;
        end
      end
      REQ: begin
        pc_d        = eff_addr;
        inst_addr_o = eff_addr;
        if (misaligned) begin
          state_d = HOLD;
          buf_v_d = 1'b1;
          buf_d   = NOP_INSTR;
          adel_d  = 1'b1;
        end else begin
          inst_req_o = 1'b1;
          if (inst_addr_ok_i) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush_i) begin
          pc_d   = flush_pc_i;
          kill_d = 1'b1;
        end
        if (inst_data_ok_i) begin
          if (kill_q || flush_i) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            buf_v_d = 1'b1;
            buf_d   = inst_rdata_i;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush_i || !stall_i) begin
          pc_d     = next_pc;
          buf_v_d  = 1'b0;
          adel_d   = 1'b0;
          pend_v_d = 1'b0;
          state_d  = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      pend_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      buf_v_q   <= 1'b0;
      buf_q     <= NOP_INSTR;
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
      kill_q    <= 1'b0;
      adel_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_v_q   <= buf_v_d;
      buf_q     <= buf_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
      kill_q    <= kill_d;
      adel_q    <= adel_d;
    end
  end

  assign if_pc_o        = pc_q;
  assign if_pc4_o       = pc_q + ADDR_W'(4);
  assign if_instr_o     = buf_v_q ? buf_q : NOP_INSTR;
  assign if_valid_o     = buf_v_q;
  assign if_stall_req_o = (state_q == REQ) || (state_q == WAIT);

endmodule
